// File: rtl/commit_arbiter_if.sv
// Unit-to-commit result handshake: per-unit valid/data/rn in,
// one-hot ready back to the units.
interface commit_arbiter_if #(
  parameter int NUM_UNITS = 5,
  parameter int DATA_W    = 64,
  parameter int RN_W      = 6
);
  logic [NUM_UNITS-1:0]        unit_valid;
  logic [NUM_UNITS*DATA_W-1:0] unit_data;
  logic [NUM_UNITS*RN_W-1:0]   unit_rn;
  logic [NUM_UNITS-1:0]        unit_ready;

  modport master (
    output unit_valid,
    output unit_data,
    output unit_rn,
    input  unit_ready
  );

  modport slave (
    input  unit_valid,
    input  unit_data,
    input  unit_rn,
    output unit_ready
  );
endinterface

// File: rtl/commit_arbiter.sv
// Commit-stage arbiter: round-robin grant of unit results onto the
// single regfile write port, with the matching busy-table clear.
module commit_arbiter #(
  parameter int NUM_UNITS    = 5,
  parameter int DATA_W       = 64,
  parameter int RN_W         = 6,
  parameter bit ZERO_DISCARD = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  commit_arbiter_if.slave   units,
  input  logic              hold,
  output logic [DATA_W-1:0] rf_writeback,
  output logic [RN_W-1:0]   rf_writeback_rn,
  output logic              rf_writeback_en,
  output logic [RN_W-1:0]   free_rn,
  output logic              free_en,
  output logic [31:0]       commit_count
);
  localparam int PW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  logic [DATA_W-1:0]    data_a [NUM_UNITS];
  logic [RN_W-1:0]      rn_a   [NUM_UNITS];
  logic [PW-1:0]        ptr_q;
  logic [PW-1:0]        idx;
  logic [PW-1:0]        gnt_idx;
  logic [NUM_UNITS-1:0] gnt;
  logic                 found;
  logic                 xfer;
  logic                 keep;
  logic [DATA_W-1:0]    sel_data;
  logic [RN_W-1:0]      sel_rn;
  int                   j;

  for (genvar g = 0; g < NUM_UNITS; g++) begin : g_unpack
    assign data_a[g] = units.unit_data[g*DATA_W +: DATA_W];
    assign rn_a[g]   = units.unit_rn[g*RN_W +: RN_W];
  end

  // Search ptr, ptr+1, ... wrapping; first valid unit wins.
  always_comb begin
    gnt      = '0;
    gnt_idx  = '0;
    idx      = '0;
    j        = 0;
    found    = 1'b0;
    sel_data = '0;
    sel_rn   = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      j = int'(ptr_q) + k;
      if (j >= NUM_UNITS) j = j - NUM_UNITS;
      idx = PW'(j);
      if (!found && units.unit_valid[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
        sel_data = data_a[idx];
        sel_rn   = rn_a[idx];
      end
    end
  end

  assign xfer = found & ~hold & ~rst_n;
  assign keep = !(ZERO_DISCARD && (sel_rn == '0));

  assign units.unit_ready = xfer ? gnt : '0;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      ptr_q           <= '0;
      rf_writeback    <= '0;
      rf_writeback_rn <= '0;
      rf_writeback_en <= 1'b0;
      free_rn         <= '0;
      free_en         <= 1'b0;
      commit_count    <= '0;
    end else begin
      rf_writeback_en <= 1'b0;
      free_en         <= 1'b0;
      if (xfer) begin
        ptr_q <= (int'(gnt_idx) == NUM_UNITS - 1)
                 ? '0 : gnt_idx + 1'b1;
        commit_count <= commit_count + 32'd1;
        // r0 results retire silently: no write, no busy-clear.
        if (keep) begin
          rf_writeback    <= sel_data;
          rf_writeback_rn <= sel_rn;
          rf_writeback_en <= 1'b1;
          free_rn         <= sel_rn;
          free_en         <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_commit_arbiter.sv
// Scoreboard bench for commit_arbiter: directed scenarios followed
// by randomized unit traffic against a queue-based reference model.
module tb_commit_arbiter;
  localparam int N  = 5;
  localparam int DW = 64;
  localparam int RW = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          hold;
  logic [DW-1:0] rf_writeback;
  logic [RW-1:0] rf_writeback_rn;
  logic          rf_writeback_en;
  logic [RW-1:0] free_rn;
  logic          free_en;
  logic [31:0]   commit_count;

  commit_arbiter_if #(.NUM_UNITS(N), .DATA_W(DW), .RN_W(RW)) ifc();

  commit_arbiter #(
    .NUM_UNITS(N), .DATA_W(DW), .RN_W(RW), .ZERO_DISCARD(1'b1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .units(ifc),
    .hold(hold),
    .rf_writeback(rf_writeback),
    .rf_writeback_rn(rf_writeback_rn),
    .rf_writeback_en(rf_writeback_en),
    .free_rn(free_rn),
    .free_en(free_en),
    .commit_count(commit_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            e;
    logic [DW-1:0] d;
    logic [RW-1:0] rn;
  } wb_t;

  wb_t           q[$];
  wb_t           w;
  int            n_tests = 0;
  int            n_fail  = 0;
  int            edge_no = 0;
  bit            mon_on  = 0;
  bit            pend  [N];
  logic [DW-1:0] pdata [N];
  logic [RW-1:0] prn   [N];
  bit            rst_v  = 1'b1;
  bit            hold_v = 1'b0;
  int            refill = 0;
  int            m_ptr  = 0;
  logic [31:0]   m_cnt  = '0;
  logic [DW-1:0] m_d    = '0;
  logic [RW-1:0] m_rn   = '0;
  bit            m_known = 1'b0;
  logic [N-1:0]  last_rdy;
  logic          last_wen;
  int            seq5 [6] = '{0, 1, 2, 3, 4, 0};

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic present(input int i, input logic [RW-1:0] rn);
    pend[i]  = 1'b1;
    pdata[i] = {$urandom, $urandom};
    prn[i]   = rn;
  endtask

  task automatic clear_units();
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
  endtask

  // One clock: drive at negedge, check grant, then advance the model.
  task automatic cycle();
    int            g;
    logic [N-1:0]  exp_rdy;
    @(negedge clk);
    rst_n = rst_v;
    hold  = hold_v;
    for (int i = 0; i < N; i++) begin
      ifc.unit_valid[i]          = pend[i];
      ifc.unit_data[i*DW +: DW]  = pdata[i];
      ifc.unit_rn[i*RW +: RW]    = prn[i];
    end
    #1;
    g = -1;
    if (!rst_v && !hold_v)
      for (int k = 0; k < N; k++)
        if (g < 0 && pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    exp_rdy  = (g < 0) ? '0 : N'(1) << g;
    last_rdy = ifc.unit_ready;
    last_wen = rf_writeback_en;
    chk("ready", last_rdy, exp_rdy);
    @(posedge clk);
    edge_no++;
    if (rst_v) begin
      m_ptr   = 0;
      m_cnt   = '0;
      m_d     = '0;
      m_rn    = '0;
      m_known = 1'b1;
    end else if (g >= 0) begin
      m_ptr = (g + 1) % N;
      m_cnt = m_cnt + 1;
      if (prn[g] != 0) begin
        q.push_back('{edge_no, pdata[g], prn[g]});
        m_d     = pdata[g];
        m_rn    = prn[g];
        m_known = 1'b1;
      end else begin
        m_known = 1'b0;
      end
      pend[g] = 1'b0;
      if (refill == 1) present(g, RW'(g + 1));
    end
    #1;
    chk("commit_count", commit_count, m_cnt);
    chk("ptr", dut.ptr_q, m_ptr);
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      if (rf_writeback_en) begin
        if (q.size() == 0) begin
          chk("wb_unexpected", rf_writeback_en, 1'b0);
        end else begin
          w = q.pop_front();
          chk("wb_edge", edge_no, w.e);
          chk("wb_rn", rf_writeback_rn, w.rn);
          chk("wb_data", rf_writeback, w.d);
          chk("free_rn", free_rn, w.rn);
        end
      end else begin
        if (q.size() != 0 && q[0].e <= edge_no) begin
          chk("wb_missing", rf_writeback_en, 1'b1);
          void'(q.pop_front());
        end
        if (m_known) begin
          chk("wb_hold_data", rf_writeback, m_d);
          chk("wb_hold_rn", rf_writeback_rn, m_rn);
        end
      end
      chk("free_en", free_en, rf_writeback_en);
    end
  end

  initial begin
    rst_n          = 1'b1;
    hold           = 1'b0;
    ifc.unit_valid = '0;
    ifc.unit_data  = '0;
    ifc.unit_rn    = '0;
    for (int i = 0; i < N; i++) begin
      pend[i]  = 1'b0;
      pdata[i] = '0;
      prn[i]   = '0;
    end

    // Reset state
    rst_v = 1'b1;
    cycle();
    cycle();
    mon_on = 1'b1;
    chk("rst_wb_en", rf_writeback_en, 1'b0);
    chk("rst_free_en", free_en, 1'b0);
    chk("rst_wb", rf_writeback, 64'd0);
    chk("rst_wb_rn", rf_writeback_rn, 6'd0);
    chk("rst_free_rn", free_rn, 6'd0);
    chk("rst_count", commit_count, 32'd0);
    rst_v = 1'b0;

    // Single unit 2 result
    pend[2]  = 1'b1;
    pdata[2] = 64'hDEAD_BEEF_0000_0001;
    prn[2]   = 6'd5;
    cycle();
    chk("t1_ready", last_rdy, 5'b00100);
    chk("t1_wb_en", rf_writeback_en, 1'b1);
    chk("t1_wb_rn", rf_writeback_rn, 6'd5);
    chk("t1_wb", rf_writeback, 64'hDEAD_BEEF_0000_0001);
    chk("t1_free_en", free_en, 1'b1);
    chk("t1_free_rn", free_rn, 6'd5);
    chk("t1_count", commit_count, 32'd1);
    chk("t1_ptr", dut.ptr_q, 3'd3);

    // All five continuously valid
    rst_v = 1'b1;
    cycle();
    rst_v  = 1'b0;
    refill = 1;
    for (int i = 0; i < N; i++) present(i, RW'(i + 1));
    for (int k = 0; k < 6; k++) begin
      cycle();
      chk("rr5_grant", last_rdy, N'(1) << seq5[k]);
      chk("rr5_wb_en", rf_writeback_en, 1'b1);
      chk("rr5_wb_rn", rf_writeback_rn, RW'(seq5[k] + 1));
    end

    // Units 0 and 3 alternate
    clear_units();
    rst_v = 1'b1;
    cycle();
    rst_v = 1'b0;
    present(0, 6'd1);
    present(3, 6'd4);
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("alt_grant", last_rdy, (k % 2 == 0) ? 5'b00001 : 5'b01000);
    end

    // hold with a write already registered
    refill = 0;
    clear_units();
    present(2, 6'd7);
    cycle();
    chk("pre_hold_grant", last_rdy, 5'b00100);
    present(1, 6'd9);
    hold_v = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("hold_ready", last_rdy, 5'b00000);
      chk("hold_ptr", dut.ptr_q, 3'd3);
      chk("hold_old_wb", last_wen, (k == 0) ? 1'b1 : 1'b0);
    end
    hold_v = 1'b0;
    cycle();
    chk("hold_release", last_rdy, 5'b00010);

    // Zero-register discard
    present(4, 6'd0);
    cycle();
    chk("zd_ready", last_rdy, 5'b10000);
    chk("zd_wb_en", rf_writeback_en, 1'b0);
    chk("zd_free_en", free_en, 1'b0);

    // Reset right after a transfer
    present(0, 6'd11);
    cycle();
    rst_v = 1'b1;
    cycle();
    chk("mid_rst_seen", last_wen, 1'b1);
    chk("mid_rst_en", rf_writeback_en, 1'b0);
    chk("mid_rst_free", free_en, 1'b0);
    chk("mid_rst_count", commit_count, 32'd0);
    chk("mid_rst_ptr", dut.ptr_q, 3'd0);
    rst_v = 1'b0;

    // commit_count wrap
    cycle();
    force dut.commit_count = 32'hFFFF_FFFF;
    #1;
    release dut.commit_count;
    m_cnt = 32'hFFFF_FFFF;
    present(1, 6'd12);
    cycle();
    chk("count_wrap", commit_count, 32'd0);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(1, 0) == 1)
          present(i, ($urandom_range(7, 0) == 0)
                     ? 6'd0 : RW'($urandom_range(63, 1)));
      hold_v = ($urandom_range(4, 0) == 0);
      rst_v  = ($urandom_range(59, 0) == 0);
      cycle();
    end

    rst_v  = 1'b0;
    hold_v = 1'b0;
    clear_units();
    cycle();
    cycle();
    chk("sb_drain", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/commit_arbiter.md
Name: commit_arbiter

Overview:
- Commit-stage arbiter for the single register-file write port.
- Collects results from the execution units: alu1, alu2, advint, memunit, branch.
- Grants one result per cycle by round-robin with a valid/ready handshake, then drives registered writeback to the regfile.
- Issues the matching busy-clear (free) to the physical-register busy table, so scheduled instructions can issue once their operands are written.

Parameters:
- NUM_UNITS, 5, number of requesting execution units; index 0=alu1, 1=alu2, 2=advint, 3=memunit, 4=branch.
- DATA_W, 64, result width.
- RN_W, 6, register-number width.
- ZERO_DISCARD, 1, when 1 a result targeting register 0 is accepted but neither written nor freed.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-high reset (1 = reset), sampled on the rising edge of clk.
- unit_valid  in  NUM_UNITS  bit i: unit i presents a result.
- unit_data  in  NUM_UNITS*DATA_W  unit i result in bits [i*DATA_W +: DATA_W].
- unit_rn  in  NUM_UNITS*RN_W  unit i destination in bits [i*RN_W +: RN_W].
- unit_ready  out  NUM_UNITS  one-hot (or zero) grant; transfer occurs when valid&ready.
- hold  in  1  regfile/commit stall; no grants while high.
- rf_writeback  out  DATA_W  write data.
- rf_writeback_rn  out  RN_W  write register number.
- rf_writeback_en  out  1  write strobe, one cycle per accepted result.
- free_rn  out  RN_W  register to mark not-busy.
- free_en  out  1  busy-clear strobe.
- commit_count  out  32  count of accepted results, wraps modulo 2^32.

Behaviour:
- **Reset (rst_n=1 at a clock edge):**
  - ptr <= 0.
  - rf_writeback, rf_writeback_rn, free_rn <= 0; rf_writeback_en, free_en <= 0.
  - commit_count <= 0.
  - unit_ready is combinational and forced to 0 while rst_n=1.
  - A handshake in the reset cycle is lost; units must re-present after reset.
- **Grant (combinational, same cycle):**
  - If hold=0 and unit_valid≠0, grant goes to the first i with unit_valid[i]=1, searching ptr, ptr+1, …, NUM_UNITS-1, 0, …, ptr-1.
  - unit_ready = onehot(grant). Otherwise unit_ready = 0.
  - unit_ready never depends on unit_data or unit_rn.
- **Handshake:**
  - Units hold valid/data/rn stable until ready. Valid may drop only after a transfer.
  - No combinational path from unit_ready back to unit_valid is required.
- **Pointer update:**
  - On a transfer from unit g: ptr <= (g+1) mod NUM_UNITS. Wrap from NUM_UNITS-1 goes to 0.
  - No transfer: ptr unchanged.
  - Worst-case wait for a continuously valid unit is NUM_UNITS-1 grants.
- **Writeback (latency 1):** a transfer at edge N drives the outputs for the cycle after edge N:
  - rf_writeback = data, rf_writeback_rn = rn, rf_writeback_en = 1.
  - free_rn = rn, free_en = 1.
  - With no transfer, both enables are 0 and the data/rn outputs hold their previous values.
- **Throughput:** back-to-back transfers every cycle are supported. The output register is overwritten each cycle; there is no internal buffering beyond that one stage.
- **ZERO_DISCARD=1 and rn==0:** the transfer completes (ready asserted, ptr advances, commit_count increments), but rf_writeback_en = free_en = 0 next cycle.
- **commit_count:** increments by 1 per transfer, including discarded transfers. 0xFFFFFFFF+1 = 0.
- **hold:**
  - hold=1 blocks new grants only.
  - A write already registered from the previous edge still appears (no retraction).
  - ptr is frozen while hold=1.
- **Same destination from two units in one cycle:** serialized by arbitration order. The later grant writes last; no hazard detection is performed here.
- **Reset mid-operation:** a write pending in the output register is discarded. Enables are 0 on the first cycle after reset.

Test Plan:
- Reset release, unit 2 valid alone with data=0xDEAD_BEEF_0000_0001, rn=5 → unit_ready=5'b00100 that cycle; next cycle rf_writeback_en=1, rf_writeback_rn=5, data matches, free_en=1, free_rn=5; commit_count=1; ptr=3.
- After reset, all five valid continuously with rn=i+1 → grants in order 0,1,2,3,4,0 on consecutive cycles; writeback rn sequence 1,2,3,4,5,1 one cycle delayed; no idle cycles.
- Units 0 and 3 continuously valid → grants alternate 0,3,0,3; neither waits more than one cycle.
- hold=1 for 3 cycles with unit 1 valid → unit_ready=0 for those cycles, ptr unchanged; on hold release unit 1 is granted immediately; a write registered before hold still strobes once.
- Unit 4 valid with rn=0 and ZERO_DISCARD=1 → ready asserted, commit_count increments, rf_writeback_en=0, free_en=0 next cycle.
- Transfer at edge N, rst_n=1 asserted for edge N+1 → enables 0 after edge N+1, commit_count=0, ptr=0. Also force commit_count=0xFFFFFFFF, one transfer → commit_count=0.
